// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexes one external BCD-to-seven-segment decoder across NUM_DIGITS digits.
// Latches BCD words by strobe, scans digits round-robin, and holds a registered pattern per digit.
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int SCAN_DIV   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      lz_blank_en,
    output logic                      load_ack,
    output logic [3:0]                dec_bcd,
    input  logic [6:0]                dec_hex,
    output logic [7*NUM_DIGITS-1:0]   hex_out,
    output logic                      frame_done
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SCAN_DIV - 1);
    localparam logic [6:0]    BLANK    = 7'h7F;

    typedef enum logic {
        LATCH = 1'b0,
        SCAN  = 1'b1
    } state_t;

    state_t                    state, state_d;
    logic [IW-1:0]             idx, idx_d;
    logic [CW-1:0]             cnt, cnt_d;
    logic [4*NUM_DIGITS-1:0]   active, active_d;
    logic [4*NUM_DIGITS-1:0]   pending, pending_d;
    logic                      pending_valid, pending_valid_d;
    logic                      capture;
    logic                      frame_done_d;
    logic [6:0]                pattern;
    logic [3:0]                act_dig [NUM_DIGITS];
    logic [6:0]                hex_r   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     lz_run;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_map
        assign act_dig[g]        = active[4*g +: 4];
        assign hex_out[7*g +: 7] = hex_r[g];
    end

    // lz_run[i]: every digit from the top down to i is zero
    always_comb begin
        lz_run = '0;
        lz_run[NUM_DIGITS-1] = (act_dig[NUM_DIGITS-1] == 4'd0);
        for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
            lz_run[i] = lz_run[i+1] && (act_dig[i] == 4'd0);
        end
    end

    always_comb begin
        pattern = dec_hex;
        if (act_dig[idx] > 4'd9) begin
            pattern = BLANK;
        end else if (lz_blank_en && (idx != '0) && lz_run[idx]) begin
            pattern = BLANK;
        end
    end

    // load_ack is combinational so a strobe landing in LATCH is acknowledged in that same cycle
    always_comb begin
        state_d         = state;
        idx_d           = idx;
        cnt_d           = cnt;
        active_d        = active;
        pending_d       = pending;
        pending_valid_d = pending_valid;
        load_ack        = 1'b0;
        dec_bcd         = 4'd0;
        capture         = 1'b0;
        frame_done_d    = 1'b0;

        if (load) begin
            pending_d       = digits_in;
            pending_valid_d = 1'b1;
        end

        case (state)
            LATCH: begin
                if (pending_valid) begin
                    active_d = pending;
                    load_ack = 1'b1;
                    // a fresh strobe this cycle stays pending for the next frame
                    if (!load) pending_valid_d = 1'b0;
                end else if (load) begin
                    active_d        = digits_in;
                    load_ack        = 1'b1;
                    pending_valid_d = 1'b0;
                end
                idx_d   = '0;
                cnt_d   = '0;
                state_d = SCAN;
            end
            SCAN: begin
                dec_bcd = act_dig[idx];
                if (cnt == LAST_CNT) begin
                    cnt_d   = '0;
                    capture = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_d      = LATCH;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx + IW'(1);
                    end
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: state_d = LATCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= LATCH;
            idx           <= '0;
            cnt           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_d;
            idx           <= idx_d;
            cnt           <= cnt_d;
            active        <= active_d;
            pending       <= pending_d;
            pending_valid <= pending_valid_d;
            frame_done    <= frame_done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) hex_r[i] <= BLANK;
        end else if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx == IW'(i)) hex_r[i] <= pattern;
            end
        end
    end

endmodule
